// File: rtl/ddr_cmd_queue.sv
// ddr_cmd_queue: first-word-fall-through request queue between the user side and the DDR controller,
// with occupancy, almost-full, synchronous flush and a sticky stall watchdog.
module ddr_cmd_queue #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int DEPTH     = 4,
    parameter int AF_LEVEL  = 3,
    parameter int STALL_MAX = 8
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       usr_valid,
    output logic                       usr_ready,
    input  logic                       usr_we,
    input  logic [ADDR_W-1:0]          usr_addr,
    input  logic [DATA_W-1:0]          usr_wdata,
    output logic                       ctl_valid,
    input  logic                       ctl_ready,
    output logic                       ctl_we,
    output logic [ADDR_W-1:0]          ctl_addr,
    output logic [DATA_W-1:0]          ctl_wdata,
    input  logic                       flush,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       almost_full,
    output logic                       stall_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(STALL_MAX + 1);
    localparam int EW = 1 + ADDR_W + DATA_W;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [CW-1:0] AF   = CW'(AF_LEVEL);
    localparam logic [SW-1:0] SMAX = SW'(STALL_MAX);

    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [SW-1:0] stall_q, stall_d;
    logic          err_q, err_d, push, pop, stalled;

    // Handshake flags come from registered count only, so no input reaches an output combinationally
    assign usr_ready   = cnt_q != FULL;
    assign ctl_valid   = cnt_q != '0;
    assign almost_full = cnt_q >= AF;
    assign count       = cnt_q;
    assign stall_err   = err_q;
    assign {ctl_we, ctl_addr, ctl_wdata} = mem[rd_q];

    always_comb begin
        push    = usr_valid & usr_ready & ~flush;
        pop     = ctl_valid & ctl_ready & ~flush;
        stalled = usr_valid & ~usr_ready;
        wr_d    = flush ? '0 : wr_q + AW'(push);
        rd_d    = flush ? '0 : rd_q + AW'(pop);
        cnt_d   = flush ? '0 : cnt_q + CW'(push) - CW'(pop);
        stall_d = !stalled ? '0 : (stall_q == SMAX ? stall_q : stall_q + 1'b1);
        err_d   = err_q | (stall_d == SMAX);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            stall_q <= '0;
            err_q   <= 1'b0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            stall_q <= stall_d;
            err_q   <= err_d;
        end
    end

    // Storage is deliberately not reset; head contents are ignored while ctl_valid is low
    always_ff @(posedge CLK) begin
        if (push) mem[wr_q] <= {usr_we, usr_addr, usr_wdata};
    end
endmodule

// File: tb/tb_ddr_cmd_queue.sv
// tb_ddr_cmd_queue: directed stimulus with a scoreboard queue; a negedge monitor checks every pop in order.
module tb_ddr_cmd_queue;
    logic        CLK = 1'b0;
    logic        RST, usr_valid, usr_we, ctl_ready, flush;
    logic [15:0] usr_addr, usr_wdata;
    logic        usr_ready, ctl_valid, ctl_we, almost_full, stall_err;
    logic [15:0] ctl_addr, ctl_wdata;
    logic [2:0]  count;
    logic [32:0] exp_q [$];
    int          pass_n = 0;
    int          total_n = 0;

    ddr_cmd_queue dut (
        .CLK(CLK), .RST(RST), .usr_valid(usr_valid), .usr_ready(usr_ready), .usr_we(usr_we),
        .usr_addr(usr_addr), .usr_wdata(usr_wdata), .ctl_valid(ctl_valid), .ctl_ready(ctl_ready),
        .ctl_we(ctl_we), .ctl_addr(ctl_addr), .ctl_wdata(ctl_wdata), .flush(flush), .count(count),
        .almost_full(almost_full), .stall_err(stall_err)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
        total_n++;
        if (act === exp) pass_n++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Monitor: any accepted pop must match the oldest expected entry
    always @(negedge CLK) begin
        if (!RST && ctl_valid === 1'b1 && ctl_ready && !flush) begin
            if (exp_q.size() == 0) begin
                total_n++;
                $display("FAIL pop_unexpected: got 0x%0h expected no entry at %0t",
                         {ctl_we, ctl_addr, ctl_wdata}, $time);
            end else begin
                chk("pop_data", {ctl_we, ctl_addr, ctl_wdata}, exp_q.pop_front());
            end
        end
    end

    // One cycle: drive at posedge+1, check acceptance at negedge, return at next posedge+1
    task automatic step(input logic v, input logic we, input logic [15:0] a, input logic [15:0] d,
                        input logic rdy, input logic fl, input logic acc);
        usr_valid = v; usr_we = we; usr_addr = a; usr_wdata = d; ctl_ready = rdy; flush = fl;
        if (acc) exp_q.push_back({we, a, d});
        @(negedge CLK);
        chk("accept", {32'd0, usr_valid & usr_ready & ~flush}, {32'd0, acc});
        if (fl) exp_q.delete();
        @(posedge CLK); #1;
    endtask

    task automatic do_reset();
        RST = 1'b1; usr_valid = 0; usr_we = 0; usr_addr = 0; usr_wdata = 0; ctl_ready = 0; flush = 0;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        exp_q.delete();
        RST = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        do_reset();
        chk("rst_count", count, 0);
        chk("rst_ctl_valid", ctl_valid, 0);
        chk("rst_usr_ready", usr_ready, 1);
        chk("rst_af", almost_full, 0);
        chk("rst_stall_err", stall_err, 0);

        // First push: visible at the head one cycle later
        step(1, 1, 16'h0010, 16'hBEEF, 0, 0, 1);
        chk("first_valid", ctl_valid, 1);
        chk("first_head", {ctl_we, ctl_addr, ctl_wdata}, {1'b1, 16'h0010, 16'hBEEF});
        chk("first_count", count, 1);
        chk("af_at1", almost_full, 0);

        step(1, 0, 16'h0011, 16'h1111, 0, 0, 1);
        chk("af_at2", almost_full, 0);
        step(1, 1, 16'h0012, 16'h2222, 0, 0, 1);
        chk("count3", count, 3);
        chk("af_at3", almost_full, 1);
        step(1, 0, 16'h0013, 16'h3333, 0, 0, 1);
        chk("count_full", count, 4);
        chk("full_usr_ready", usr_ready, 0);
        step(1, 1, 16'h0099, 16'h9999, 0, 0, 0);
        chk("fifth_rejected", count, 4);
        chk("head_stable", {ctl_we, ctl_addr, ctl_wdata}, {1'b1, 16'h0010, 16'hBEEF});

        // Full with ctl_ready high: no push until a pop frees a slot
        step(1, 1, 16'h0098, 16'h9898, 1, 0, 0);
        chk("after_pop_ready", usr_ready, 1);
        chk("after_pop_count", count, 3);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 0, 0);
        chk("drained_count", count, 0);
        chk("drained_valid", ctl_valid, 0);

        // Steady push+pop at count=2 across several pointer wraps
        step(1, 1, 16'h0020, 16'hA020, 0, 0, 1);
        step(1, 0, 16'h0021, 16'hA021, 0, 0, 1);
        for (int a = 16'h22; a <= 16'h2F; a++) begin
            step(1, a[0], 16'(a), 16'hA000 | 16'(a), 1, 0, 1);
            chk("steady_count", count, 2);
        end
        step(0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0);
        chk("wrap_drained", count, 0);

        // Flush on a full queue drops the same-cycle push and pop
        for (int i = 0; i < 4; i++) step(1, 1, 16'h0030 + 16'(i), 16'hC000 + 16'(i), 0, 0, 1);
        step(1, 1, 16'h0040, 16'hC040, 1, 1, 0);
        chk("flush_count", count, 0);
        chk("flush_valid", ctl_valid, 0);
        step(0, 0, 0, 0, 1, 0, 0);
        chk("flush_push_dropped", ctl_valid, 0);
        step(1, 0, 16'h0041, 16'hC041, 0, 0, 1);
        chk("post_flush_head", {ctl_we, ctl_addr, ctl_wdata}, {1'b0, 16'h0041, 16'hC041});
        step(0, 0, 0, 0, 1, 0, 0);

        // Stall watchdog: eight stalled cycles set the sticky error
        for (int i = 0; i < 4; i++) step(1, 0, 16'h0050 + 16'(i), 16'hD000 + 16'(i), 0, 0, 1);
        for (int i = 0; i < 7; i++) step(1, 0, 16'h00EE, 16'hEEEE, 0, 0, 0);
        chk("stall7_no_err", stall_err, 0);
        step(1, 0, 16'h00EE, 16'hEEEE, 0, 0, 0);
        chk("stall8_err", stall_err, 1);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, 0, 0);
        chk("err_after_drain", stall_err, 1);
        step(0, 0, 0, 0, 0, 1, 0);
        chk("err_after_flush", stall_err, 1);

        // Reset mid-operation clears everything, including the sticky error
        step(1, 1, 16'h0060, 16'hF060, 0, 0, 1);
        chk("pre_rst_count", count, 1);
        do_reset();
        chk("rst2_count", count, 0);
        chk("rst2_valid", ctl_valid, 0);
        chk("rst2_stall_err", stall_err, 0);
        step(1, 1, 16'h0070, 16'hF070, 0, 0, 1);
        step(0, 0, 0, 0, 1, 0, 0);
        chk("final_count", count, 0);
        chk("scoreboard_empty", 33'(exp_q.size()), 0);

        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end
endmodule

// File: doc/ddr_cmd_queue.md
Name: ddr_cmd_queue

Overview:
- Upstream command buffer between the user-side request generator and DDR_CONTROLLER, on the CLK domain of ddr_interface.
- Accepts read/write requests (address plus write data) through a valid/ready handshake and stores them in order.
- Presents them first-word-fall-through to the controller, which pops through its own valid/ready handshake.
- Provides occupancy, an almost-full hint, a synchronous flush and a sticky stall watchdog error.

Parameters:
ADDR_W, 16, request address width
DATA_W, 16, write data width
DEPTH, 4, queue entries (power of two, >=2)
AF_LEVEL, 3, almost_full asserts when count >= AF_LEVEL
STALL_MAX, 8, consecutive usr-stall cycles before stall_err sets

Ports:
CLK  in  1  controller-side clock (all logic rising-edge)
RST  in  1  synchronous active-high reset
usr_valid  in  1  user request present
usr_ready  out  1  queue can accept (= count != DEPTH)
usr_we  in  1  1=write, 0=read
usr_addr  in  ADDR_W  request address
usr_wdata  in  DATA_W  write data (stored, ignored by consumer for reads)
ctl_valid  out  1  head entry valid (= count != 0)
ctl_ready  in  1  controller pops head
ctl_we  out  1  head we
ctl_addr  out  ADDR_W  head address
ctl_wdata  out  DATA_W  head write data
flush  in  1  discard all entries
count  out  $clog2(DEPTH)+1  current occupancy
almost_full  out  1  count >= AF_LEVEL
stall_err  out  1  sticky watchdog error

Behaviour:
- One clock (CLK); reset is synchronous and active-high (RST), sampled only on rising CLK.
- Reset values: count=0, wr_ptr=rd_ptr=0, ctl_valid=0, usr_ready=1, almost_full=0, stall_err=0, stall counter=0. Storage contents are not reset; ctl_we/addr/wdata are don't-care while ctl_valid=0.
- push = usr_valid & usr_ready & !flush; pop = ctl_valid & ctl_ready & !flush.
- Push: write {usr_we, usr_addr, usr_wdata} to mem[wr_ptr]; wr_ptr increments modulo DEPTH.
- Pop: rd_ptr increments modulo DEPTH.
- Head outputs are driven from mem[rd_ptr] (FWFT).
- Latency: a request pushed into an empty queue at edge N gives ctl_valid=1 with that entry after edge N (1 cycle). No combinational pass-through usr->ctl.
- count: +1 on push only, -1 on pop only, unchanged on both or neither. Push and pop in the same cycle are legal at any 0<count<DEPTH.
- At count=DEPTH, usr_ready=0 even if ctl_ready=1; a pop that cycle frees the slot for the next cycle.
- At count=0 no pop is possible, because ctl_valid=0.
- usr_ready, ctl_valid and almost_full derive from registered count only (no input->output combinational path).
- Ordering is strict FIFO; read-after-write order is preserved.
- Pointers wrap silently from DEPTH-1 to 0.
- flush=1: next state has count=0, wr_ptr=rd_ptr=0. Any push or pop that cycle is dropped or ignored. stall_err and the stall counter are unaffected.
- Stall watchdog:
  - The counter increments each cycle with usr_valid=1 and usr_ready=0, saturating at STALL_MAX.
  - It clears on any cycle without that condition.
  - stall_err sets when the counter reaches STALL_MAX and stays set until RST.
- RST asserted mid-operation overrides push, pop and flush; all state returns to reset values the next cycle.
- Consumer rule: ctl outputs are stable while ctl_valid=1 and ctl_ready=0.

Test Plan:
- Reset then push write A=0x0010 D=0xBEEF with ctl_ready=0 -> next cycle ctl_valid=1, ctl_we=1, ctl_addr=0x0010, ctl_wdata=0xBEEF, count=1.
- Push 4 requests with ctl_ready=0 (DEPTH=4) -> count=4, usr_ready=0, almost_full=1 from count=3. A 5th usr_valid is not accepted.
- Raise ctl_ready with full queue -> entries pop in push order, one per cycle; usr_ready returns 1 the cycle after the first pop.
- Continuous usr_valid and ctl_ready at count=2, pushing addresses 0x20..0x2F -> count stays 2; outputs appear in order; pointers wrap through 0 with no loss.
- Full queue, flush=1 with usr_valid=1 and ctl_ready=1 -> next cycle count=0, ctl_valid=0; the same-cycle push is dropped.
- Hold usr_valid=1 with full queue and ctl_ready=0 for 8 cycles -> stall_err=1. It stays 1 after draining and after flush; RST clears it.
